fixed_point_adder_acc: RTL and testbench

FIXED_POINT_ADDER_ACC -- requirements
Module: fixed_point_adder_acc

---
 rtl/fixed_point_adder_acc.sv | 163 ++++++++++++++++
 tb/tb_fixed_point_adder_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_adder_acc.sv
// -----------------------------------------------------------------------------
// fixed_point_adder_acc
//
// Two-stage signed fixed-point adder with N_CH independent accumulators.
// Each accepted sample either adds two operands (mode 0) or adds operand A
// to the accumulator of its channel (mode 1). In mode 1 the result is also
// written back to that accumulator. i_clr makes the accumulator read as zero
// for that one sample.
//
// Optional feature: define FXP_ADD_SAT_EN to saturate overflowing results to
// the signed DATA_W range. This applies to both o_data and the accumulator.
// Without it, results wrap to the low DATA_W bits. o_ovf reports the true
// overflow in both builds.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_valid / o_ready   input handshake (o_ready = !o_valid | i_ready)
//   i_a, i_b            signed operands (i_b is used in add mode only)
//   i_ch                channel index (out-of-range values map to channel 0)
//   i_mode, i_clr       0 = A+B, 1 = acc[ch]+A; clr zeroes acc for this sample
//   o_valid / i_ready   output handshake
//   o_data, o_ch, o_ovf result, its channel, overflow flag
// -----------------------------------------------------------------------------
module fixed_point_adder_acc #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [CH_W-1:0]   i_ch,
    input  logic              i_mode,
    input  logic              i_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_ovf
);

`ifdef FXP_ADD_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    // The whole pipeline advances together. The output register is free
    // when it is empty or is being consumed downstream.
    logic en;
    assign en      = !o_valid | i_ready;
    assign o_ready = en;

    // Out-of-range channel indices are folded to channel 0 on entry.
    // Everything downstream can then index the accumulators safely.
    logic [CH_W-1:0] ch_map;
    assign ch_map = (32'(i_ch) < N_CH) ? i_ch : '0;

    // ---------------- Stage 1: input capture ----------------
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_a_reg;
    logic [DATA_W-1:0] s1_b_reg;
    logic [CH_W-1:0]   s1_ch_reg;
    logic              s1_mode_reg;
    logic              s1_clr_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_ch_reg    <= '0;
            s1_mode_reg  <= 1'b0;
            s1_clr_reg   <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= i_valid;
            s1_a_reg     <= i_a;
            s1_b_reg     <= i_b;
            s1_ch_reg    <= ch_map;
            s1_mode_reg  <= i_mode;
            s1_clr_reg   <= i_clr;
        end
    end

    // ---------------- Accumulators ----------------
    // The read is combinational so that a back-to-back accumulate on the
    // same channel sees the value written on the previous edge.
    logic [DATA_W-1:0] acc_rd_arr [N_CH];
    logic [DATA_W-1:0] acc_rd;
    logic [DATA_W-1:0] result_next;

    assign acc_rd = acc_rd_arr[s1_ch_reg];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_acc
            logic [DATA_W-1:0] acc_reg;
            logic              acc_we;

            // Only a valid accumulate sample on this channel writes.
            // This excludes bubbles, add mode and stalls.
            assign acc_we = en && s1_valid_reg && s1_mode_reg &&
                            (32'(s1_ch_reg) == gi);

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    acc_reg <= '0;
                end else if (acc_we) begin
                    acc_reg <= result_next;
                end
            end

            assign acc_rd_arr[gi] = acc_reg;
        end
    endgenerate

    // ---------------- Stage 2: arithmetic ----------------
    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sum_wide;
    logic              ovf_next;

    always_comb begin
        operand = '0;
        if (!s1_mode_reg) begin
            operand = s1_b_reg;
        end else if (!s1_clr_reg) begin
            operand = acc_rd;
        end
    end

    // Sign-extend both operands by one bit, so the sum is exact.
    assign sum_wide = {s1_a_reg[DATA_W-1], s1_a_reg} + {operand[DATA_W-1], operand};

    // The result fits iff the two top bits of the exact sum agree.
    assign ovf_next = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];

    always_comb begin
        result_next = sum_wide[DATA_W-1:0];
`ifdef FXP_ADD_SAT_EN
        // The top bit of the exact sum gives the true sign of the result.
        if (ovf_next) begin
            result_next = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            o_ovf   <= 1'b0;
        end else if (en) begin
            o_valid <= s1_valid_reg;
            o_data  <= result_next;
            o_ch    <= s1_ch_reg;
            o_ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_fixed_point_adder_acc.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_adder_acc
//
// Scoreboard bench for fixed_point_adder_acc (DATA_W=8, N_CH=4).
// The driver computes each expected result with integer arithmetic and a
// per-channel integer accumulator model, then queues it. An independent
// monitor pops and compares on every output handshake. The monitor also
// checks that o_ready is correct and that outputs stay stable while stalled.
// -----------------------------------------------------------------------------
module tb_fixed_point_adder_acc;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic [1:0] i_ch = '0;
    logic       i_mode = 1'b0;
    logic       i_clr = 1'b0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic [1:0] o_ch;
    logic       o_ovf;

    always #5 clk = ~clk;

    fixed_point_adder_acc #(.DATA_W(8), .N_CH(4)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_ch    (i_ch),
        .i_mode  (i_mode),
        .i_clr   (i_clr),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_ovf   (o_ovf)
    );

    int compared   = 0;
    int mismatched = 0;

    // Each expected entry is packed as {data[7:0], ch[1:0], ovf}.
    logic [10:0] exp_q[$];
    int          acc_m[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer sum, then saturate or wrap into int8.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] ch, input logic mode,
                                          input logic clr);
        int c, sa, op, t, r;
        logic ovf;
        c  = (int'(ch) >= 4) ? 0 : int'(ch);
        sa = int'($signed(a));
        if (mode) op = clr ? 0 : acc_m[c];
        else      op = int'($signed(b));
        t   = sa + op;
        ovf = (t > 127) || (t < -128);
`ifdef FXP_ADD_SAT_EN
        r = (t > 127) ? 127 : ((t < -128) ? -128 : t);
`else
        r = t;
        if (r > 127)       r = r - 256;
        else if (r < -128) r = r + 256;
`endif
        if (mode) acc_m[c] = r;
        return {8'(r), 2'(c), ovf};
    endfunction

    // Presents one sample and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ch,
                        input logic mode, input logic clr);
        bit ok = 0;
        int waited = 0;
        i_valid = 1'b1; i_a = a; i_b = b; i_ch = ch; i_mode = mode; i_clr = clr;
        exp_q.push_back(model(a, b, ch, mode, clr));
        while (!ok) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk); #1;
            if (!ok) begin
                waited++;
                if (waited > 100) begin
                    check("send_timeout", 32'd1, 32'd0);
                    break;
                end
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor process: it is independent of the driver.
    logic        stall_prev = 1'b0;
    logic [10:0] held;
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                stall_prev = 1'b0;
            end else begin
                check("o_ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
                if (stall_prev) begin
                    check("stall_hold", {20'd0, o_valid, o_data, o_ch, o_ovf}, {20'd0, 1'b1, held});
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {21'd0, o_data, o_ch, o_ovf}, 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(o_data), 32'(e[10:3]));
                        check("out_ch",   32'(o_ch),   32'(e[2:1]));
                        check("out_ovf",  32'(o_ovf),  32'(e[0]));
                        $display("out ch=%0d data=0x%02h ovf=%0b", o_ch, o_data, o_ovf);
                    end
                end
                stall_prev = o_valid && !i_ready;
                held       = {o_data, o_ch, o_ovf};
            end
        end
    end

    initial begin
        bit done;
        for (int i = 0; i < 4; i++) acc_m[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_ch",    32'(o_ch),    32'd0);
        check("rst_o_ovf",   32'(o_ovf),   32'd0);
        i_reset = 1'b0;
        @(posedge clk); #1;
        check("rst_o_ready", 32'(o_ready), 32'd1);

        // Add 0x30 + 0x20. The result is valid exactly two edges after the input.
        send(8'h30, 8'h20, 2'd0, 1'b0, 1'b0);
        check("lat_cycle1_invalid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", 32'(o_valid), 32'd1);
        check("add_0x50", 32'(o_data), 32'h50);
        @(posedge clk); #1;

        // Overflow cases
        send(8'h70, 8'h20, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
`ifdef FXP_ADD_SAT_EN
        check("ovf_pos_data", 32'(o_data), 32'h7F);
`else
        check("ovf_pos_data", 32'(o_data), 32'h90);
`endif
        check("ovf_pos_flag", 32'(o_ovf), 32'd1);
        send(8'h80, 8'hFF, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
`ifdef FXP_ADD_SAT_EN
        check("ovf_neg_data", 32'(o_data), 32'h80);
`else
        check("ovf_neg_data", 32'(o_data), 32'h7F);
`endif
        check("ovf_neg_flag", 32'(o_ovf), 32'd1);
        drain();

        // Back-to-back accumulates with another channel interleaved
        send(8'h10, 8'h00, 2'd1, 1'b1, 1'b1);
        send(8'h10, 8'h00, 2'd1, 1'b1, 1'b0);
        send(8'h05, 8'h00, 2'd2, 1'b1, 1'b1);
        send(8'h10, 8'h00, 2'd1, 1'b1, 1'b0);
        drain();
        check("acc_ch1_model", 32'(acc_m[1]), 32'h30);

        // Backpressure: downstream stalls while three samples are issued.
        fork
            begin
                send(8'h11, 8'h00, 2'd3, 1'b1, 1'b1);
                send(8'h22, 8'h00, 2'd3, 1'b1, 1'b0);
                send(8'h7F, 8'h01, 2'd2, 1'b0, 1'b0);
            end
            begin
                i_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                check("bp_o_ready_low", 32'(o_ready), 32'd0);
                check("bp_o_valid_held", 32'(o_valid), 32'd1);
                i_ready = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random downstream backpressure
        done = 0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream with two samples in flight.
        // A sample presented during reset must not be captured.
        send(8'h40, 8'h00, 2'd1, 1'b1, 1'b1);
        send(8'h40, 8'h00, 2'd1, 1'b1, 1'b0);
        i_reset = 1'b1;
        i_valid = 1'b1; i_a = 8'h55; i_b = 8'h01; i_ch = 2'd2; i_mode = 1'b0; i_clr = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_no_capture", 32'(o_valid), 32'd0);
        send(8'h01, 8'h00, 2'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("post_rst_valid", 32'(o_valid), 32'd1);
        check("post_rst_acc",   32'(o_data),  32'h01);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
